vga_pixel_pipeline: RTL and testbench

- Downstream stage of the VGA timing controller: consumes its pixel_x/pixel_y/video_on/hsync/vsync and produces registered RGB plus sync delayed to match.
- Pixel source is either an on-chip frame buffer (256x240, each stored row shown on two display lines) or one of three built-in test patterns.
- Issues frame-buffer read addresses, absorbs RAM read latency, blanks outside the active area and counts frames.

---
 rtl/vga_pixel_pipeline.sv | 166 ++++++++++++++++
 tb/tb_vga_pixel_pipeline.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipeline.sv
// Pixel stage behind the VGA timing controller: picks frame-buffer or test-pattern
// colour, hides RAM read latency and delays syncs so they stay aligned with RGB.
module vga_pixel_pipeline #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 16,
  parameter int PIX_W       = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [1:0]        mode_sel,
  input  logic [2:0]        fill_color,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {
    MODE_FB    = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_FILL  = 2'd3
  } mode_e;

  // Everything that must arrive at the colour stage together with mem_rdata.
  typedef struct packed {
    logic       von;
    logic       hs;
    logic       vs;
    mode_e      mode;
    logic [2:0] bars;
    logic       chk;
    logic [2:0] fill;
  } stage_t;

  localparam stage_t STAGE_RST = '{von: 1'b0, hs: 1'b1, vs: 1'b1, mode: MODE_FB,
                                   bars: 3'd0, chk: 1'b0, fill: 3'd0};

  logic              r_vsync_d;
  mode_e             r_mode;
  logic [15:0]       r_frame_count;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd_en;
  stage_t            r_pipe [0:MEM_LATENCY];
  logic [3:0]        r_vga_r, r_vga_g, r_vga_b;
  logic              r_hsync, r_vsync;

  logic              w_frame_start;
  mode_e             w_mode;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  stage_t            w_stage_in;
  stage_t            w_tail;
  logic [2:0]        w_rgb;
  logic              w_unused;

  // Line doubling drops pixel_y[0]; the frame buffer is only 256 columns wide.
  assign w_unused = ^{pixel_x[9:8], pixel_y[9], pixel_y[0]};

  // A pixel sampled on the frame-start cycle already uses the newly latched mode.
  assign w_frame_start = r_vsync_d & ~vsync_in;
  assign w_mode        = w_frame_start ? mode_e'(mode_sel) : r_mode;
  assign w_rd_en       = video_on & (w_mode == MODE_FB);
  assign w_addr        = ADDR_W'({pixel_y[8:1], pixel_x[7:0]});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the stages shift in lockstep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_d     <= 1'b1;
      r_mode        <= MODE_FB;
      r_frame_count <= '0;
    end else begin
      r_vsync_d <= vsync_in;
      if (w_frame_start) begin
        r_mode        <= mode_e'(mode_sel);
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_stage_in      = STAGE_RST;
    w_stage_in.von  = video_on;
    w_stage_in.hs   = hsync_in;
    w_stage_in.vs   = vsync_in;
    w_stage_in.mode = w_mode;
    w_stage_in.bars = pixel_x[7:5];
    w_stage_in.chk  = pixel_x[4] ^ pixel_y[4];
    w_stage_in.fill = fill_color;
  end

  // Stage A: address/strobe register; the address holds while no read is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr  <= '0;
      r_mem_rd_en <= 1'b0;
    end else begin
      r_mem_rd_en <= w_rd_en;
      if (w_rd_en) r_mem_addr <= w_addr;
    end
  end

  // NOTE: the delay line is a handful of flops, not a RAM, so it is reset:
  // syncs must idle high and video_on low straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= MEM_LATENCY; i++) r_pipe[i] <= STAGE_RST;
    end else begin
      r_pipe[0] <= w_stage_in;
      for (int i = 1; i <= MEM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail = r_pipe[MEM_LATENCY];

  // NOTE: w_rgb gets a default before any branch so no path can infer a latch.
  always_comb begin
    w_rgb = 3'b000;
    if (w_tail.von) begin
      unique case (w_tail.mode)
        MODE_FB:    w_rgb = mem_rdata[2:0];
        MODE_BARS:  w_rgb = w_tail.bars;
        MODE_CHECK: w_rgb = {3{w_tail.chk}};
        MODE_FILL:  w_rgb = w_tail.fill;
      endcase
    end
  end

  // Stage C: expand RGB111 to full-scale 4-bit channels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vga_r <= 4'h0;
      r_vga_g <= 4'h0;
      r_vga_b <= 4'h0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_vga_r <= {4{w_rgb[2]}};
      r_vga_g <= {4{w_rgb[1]}};
      r_vga_b <= {4{w_rgb[0]}};
      r_hsync <= w_tail.hs;
      r_vsync <= w_tail.vs;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_rd_en   = r_mem_rd_en;
  assign vga_r       = r_vga_r;
  assign vga_g       = r_vga_g;
  assign vga_b       = r_vga_b;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Bench for vga_pixel_pipeline: two instances (read latency 1 and 2) share stimulus
// and are compared against a queue-based model, constant vectors and corner sequences.
module tb_vga_pixel_pipeline;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic [1:0] mode_sel = '0;
  logic [2:0] fill_color = '0;

  logic [15:0] mem_addr1, mem_addr2;
  logic        mem_rd_en1, mem_rd_en2;
  logic [2:0]  mem_rdata1, mem_rdata2;
  logic [3:0]  vga_r1, vga_g1, vga_b1, vga_r2, vga_g2, vga_b2;
  logic        hsync1, vsync1, hsync2, vsync2;
  logic [15:0] frame_count1, frame_count2;

  vga_pixel_pipeline #(.MEM_LATENCY(1), .ADDR_W(16), .PIX_W(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y), .mode_sel(mode_sel),
    .fill_color(fill_color), .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1),
    .mem_rdata(mem_rdata1), .vga_r(vga_r1), .vga_g(vga_g1), .vga_b(vga_b1),
    .hsync(hsync1), .vsync(vsync1), .frame_count(frame_count1));

  vga_pixel_pipeline #(.MEM_LATENCY(2), .ADDR_W(16), .PIX_W(3)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y), .mode_sel(mode_sel),
    .fill_color(fill_color), .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2),
    .mem_rdata(mem_rdata2), .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2),
    .hsync(hsync2), .vsync(vsync2), .frame_count(frame_count2));

  always #5 clk = ~clk;

  // Frame-buffer RAM models with 1 and 2 clocks of read latency.
  logic [2:0] mem [0:65535];
  logic [2:0] ram1_q;
  logic [2:0] ram2_q [0:1];
  always @(posedge clk) ram1_q <= mem[mem_addr1];
  always @(posedge clk) begin
    ram2_q[0] <= mem[mem_addr2];
    ram2_q[1] <= ram2_q[0];
  end
  assign mem_rdata1 = ram1_q;
  assign mem_rdata2 = ram2_q[1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: colour rules in plain arithmetic plus per-DUT output queues.
  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   act_mode, exp_cnt1, exp_cnt2, exp_addr;
  bit   prev_vs;

  function automatic logic [11:0] ref_rgb(int mode, int x, int y, bit von, int fill, int memv);
    int c;
    if (!von) return 12'h000;
    case (mode)
      0:       c = memv;
      1:       c = (x / 32) % 8;
      2:       c = (((x / 16) % 2) != ((y / 16) % 2)) ? 7 : 0;
      default: c = fill;
    endcase
    return {((c / 4) % 2 != 0) ? 4'hF : 4'h0,
            ((c / 2) % 2 != 0) ? 4'hF : 4'h0,
            (c % 2 != 0)       ? 4'hF : 4'h0};
  endfunction

  task automatic reset_model();
    exp_t r;
    r.rgb = 12'h000; r.hs = 1'b1; r.vs = 1'b1;
    act_mode = 0; prev_vs = 1'b1; exp_cnt1 = 0; exp_cnt2 = 0; exp_addr = 0;
    q1.delete(); q2.delete();
    repeat (2) q1.push_back(r);
    repeat (3) q2.push_back(r);
  endtask

  // Apply one pixel sample, advance one clock and compare both DUTs with the model.
  task automatic drive(input int x, input int y, input bit von, input bit hs, input bit vs,
                       input int msel, input int fill);
    exp_t e;
    int   addr;
    bit   rd;
    pixel_x    = 10'(x);
    pixel_y    = 10'(y);
    video_on   = von;
    hsync_in   = hs;
    vsync_in   = vs;
    mode_sel   = 2'(msel);
    fill_color = 3'(fill);
    if (prev_vs && !vs) begin
      act_mode = msel;
      exp_cnt1 = (exp_cnt1 + 1) % 65536;
      exp_cnt2 = (exp_cnt2 + 1) % 65536;
    end
    prev_vs = vs;
    addr = ((y / 2) % 256) * 256 + (x % 256);
    rd   = von && (act_mode == 0);
    if (rd) exp_addr = addr;
    e.rgb = ref_rgb(act_mode, x, y, von, fill, int'(mem[addr]));
    e.hs  = hs;
    e.vs  = vs;
    q1.push_back(e);
    q2.push_back(e);
    @(posedge clk);
    #1;
    check("rd_en_l1", mem_rd_en1, rd);
    check("rd_en_l2", mem_rd_en2, rd);
    check("addr_l1", mem_addr1, exp_addr);
    check("addr_l2", mem_addr2, exp_addr);
    check("fcount_l1", frame_count1, exp_cnt1);
    check("fcount_l2", frame_count2, exp_cnt2);
    e = q1.pop_front();
    check("rgb_l1", {vga_r1, vga_g1, vga_b1}, e.rgb);
    check("hsync_l1", hsync1, e.hs);
    check("vsync_l1", vsync1, e.vs);
    e = q2.pop_front();
    check("rgb_l2", {vga_r2, vga_g2, vga_b2}, e.rgb);
    check("hsync_l2", hsync2, e.hs);
    check("vsync_l2", vsync2, e.vs);
  endtask

  typedef struct {
    int          mode;
    int          x;
    int          y;
    bit          von;
    int          fill;
    int          ram;
    bit          exp_rd;
    int          exp_addr;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t tbl [12];
  int   fc_before;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 224,   0, 1'b1, 0, 0, 1'b0, 0,       12'hFFF};
    tbl[1]  = '{1,   0,   0, 1'b1, 0, 0, 1'b0, 0,       12'h000};
    tbl[2]  = '{1, 160,   7, 1'b1, 0, 0, 1'b0, 0,       12'hF0F};
    tbl[3]  = '{1, 100,  50, 1'b1, 0, 0, 1'b0, 0,       12'h0FF};
    tbl[4]  = '{2,  16,   0, 1'b1, 0, 0, 1'b0, 0,       12'hFFF};
    tbl[5]  = '{2,  16,  16, 1'b1, 0, 0, 1'b0, 0,       12'h000};
    tbl[6]  = '{2,   0,  16, 1'b1, 0, 0, 1'b0, 0,       12'hFFF};
    tbl[7]  = '{3,  40,  40, 1'b1, 2, 0, 1'b0, 0,       12'h0F0};
    tbl[8]  = '{3, 300,  10, 1'b0, 7, 0, 1'b0, 0,       12'h000};
    tbl[9]  = '{0,   5,   3, 1'b1, 0, 4, 1'b1, 'h0105,  12'hF00};
    tbl[10] = '{0, 255, 239, 1'b1, 0, 3, 1'b1, 'h77FF,  12'h0FF};
    tbl[11] = '{0, 300, 100, 1'b0, 0, 7, 1'b0, 0,       12'h000};

    for (int i = 0; i < 65536; i++) mem[i] = 3'($urandom_range(0, 7));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb_l1", {vga_r1, vga_g1, vga_b1}, 12'h000);
    check("rst_rgb_l2", {vga_r2, vga_g2, vga_b2}, 12'h000);
    check("rst_syncs", {hsync1, vsync1, hsync2, vsync2}, 4'b1111);
    check("rst_rd_en", {mem_rd_en1, mem_rd_en2}, 2'b00);
    check("rst_addr", mem_addr1, 16'h0000);
    check("rst_fcount", frame_count1, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();

    // Constant vectors, each behind its own frame start.
    for (int i = 0; i < 12; i++) begin
      mem[((tbl[i].y / 2) % 256) * 256 + (tbl[i].x % 256)] = 3'(tbl[i].ram);
      drive(0, 0, 1'b0, 1'b1, 1'b1, tbl[i].mode, tbl[i].fill);
      drive(tbl[i].x, tbl[i].y, tbl[i].von, 1'b1, 1'b0, tbl[i].mode, tbl[i].fill);
      check("tbl_rd_en", mem_rd_en1, tbl[i].exp_rd);
      if (tbl[i].exp_rd) check("tbl_addr", mem_addr1, tbl[i].exp_addr);
      drive(0, 0, 1'b0, 1'b1, 1'b0, tbl[i].mode, tbl[i].fill);
      drive(0, 0, 1'b0, 1'b1, 1'b0, tbl[i].mode, tbl[i].fill);
      check("tbl_rgb_l1", {vga_r1, vga_g1, vga_b1}, tbl[i].exp_rgb);
      drive(0, 0, 1'b0, 1'b1, 1'b0, tbl[i].mode, tbl[i].fill);
      check("tbl_rgb_l2", {vga_r2, vga_g2, vga_b2}, tbl[i].exp_rgb);
    end

    // Latency and sync alignment: white bar and hsync fall land together.
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1, 0);
    drive(224, 0, 1'b1, 1'b0, 1'b0, 1, 0);
    check("align_hs_t1", hsync1, 1'b1);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1, 0);
    check("align_hs_t2", hsync1, 1'b1);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1, 0);
    check("align_hs_t3", hsync1, 1'b0);
    check("align_rgb_t3", {vga_r1, vga_g1, vga_b1}, 12'hFFF);

    // Mode change mid-frame is ignored until the next vsync falling edge.
    mem[16'h0105] = 3'b100;
    mem[16'h0010] = 3'b001;
    drive(0, 0, 1'b0, 1'b1, 1'b1, 0, 0);
    drive(5, 3, 1'b1, 1'b1, 1'b0, 0, 0);
    check("fb_addr", mem_addr1, 16'h0105);
    check("fb_rd_en", mem_rd_en1, 1'b1);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    check("fb_rgb", {vga_r1, vga_g1, vga_b1}, 12'hF00);
    drive(16, 0, 1'b1, 1'b1, 1'b0, 2, 0);
    check("midframe_rd_en", mem_rd_en1, 1'b1);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 2, 0);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 2, 0);
    check("midframe_rgb", {vga_r1, vga_g1, vga_b1}, 12'h00F);
    fc_before = exp_cnt1;
    drive(0, 0, 1'b0, 1'b1, 1'b1, 2, 0);
    drive(16, 0, 1'b1, 1'b1, 1'b0, 2, 0);
    check("frame_inc", frame_count1, 16'((fc_before + 1) % 65536));
    check("chk_rd_en", mem_rd_en1, 1'b0);
    drive(16, 16, 1'b1, 1'b1, 1'b0, 2, 0);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 2, 0);
    check("chk_white", {vga_r1, vga_g1, vga_b1}, 12'hFFF);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 2, 0);
    check("chk_black", {vga_r1, vga_g1, vga_b1}, 12'h000);

    // Frame counter wrap.
    drive(0, 0, 1'b0, 1'b1, 1'b1, 2, 0);
    force u_dut1.r_frame_count = 16'hFFFF;
    force u_dut2.r_frame_count = 16'hFFFF;
    #1;
    release u_dut1.r_frame_count;
    release u_dut2.r_frame_count;
    exp_cnt1 = 65535;
    exp_cnt2 = 65535;
    check("preload", frame_count1, 16'hFFFF);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 2, 0);
    check("wrap_l1", frame_count1, 16'h0000);
    check("wrap_l2", frame_count2, 16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(0, 399)), int'($urandom_range(0, 261)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)));
    end

    // Async reset mid-line with non-zero colour on the outputs.
    drive(0, 0, 1'b0, 1'b1, 1'b1, 3, 7);
    repeat (4) drive(10, 10, 1'b1, 1'b0, 1'b0, 3, 7);
    check("pre_reset_rgb", {vga_r1, vga_g1, vga_b1}, 12'hFFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rgb_l1", {vga_r1, vga_g1, vga_b1}, 12'h000);
    check("async_rgb_l2", {vga_r2, vga_g2, vga_b2}, 12'h000);
    check("async_syncs", {hsync1, vsync1, hsync2, vsync2}, 4'b1111);
    check("async_fcount", frame_count1, 16'h0000);
    check("async_rd_en", mem_rd_en1, 1'b0);
    video_on = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();
    drive(0, 0, 1'b0, 1'b1, 1'b1, 3, 7);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 3, 7);
    drive(40, 20, 1'b1, 1'b1, 1'b0, 3, 7);
    check("post_rst_t1", {vga_r1, vga_g1, vga_b1}, 12'h000);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 3, 7);
    check("post_rst_t2", {vga_r1, vga_g1, vga_b1}, 12'h000);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 3, 7);
    check("post_rst_t3", {vga_r1, vga_g1, vga_b1}, 12'hFFF);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 3, 7);
    check("post_rst_l2", {vga_r2, vga_g2, vga_b2}, 12'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
